accumulate_host: RTL and testbench
==================================

Name: accumulate_host

Overview:
Host-side sequencer that sits directly upstream and downstream of the generated `main` accumulate kernel. `main` computes in-place running sums over a 1000×64-bit array.
- Loads the kernel array from a valid/ready input stream through the kernel's controlArr port.
- Launches the kernel with r_enable and waits for w_enable.
- Streams the resulting prefix-summed array back out on a valid/ready output stream.
- Owns the array (controlArr=1) at all times except launch/run.

Parameters:
DEPTH, 1000, kernel array length (words loaded/drained per job)
ADDR_W, 10, kernel address width
DATA_W, 64, word width (signed)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  job request pulse; sampled only in IDLE
init_i  in  ADDR_W  first index to accumulate; latched on accepted start
init_acc  in  DATA_W  initial accumulator; latched on accepted start
in_valid  in  1  load stream valid
in_ready  out  1  load stream ready
in_data  in  DATA_W  load word
out_valid  out  1  drain stream valid
out_ready  in  1  drain stream ready
out_data  out  DATA_W  drain word
out_last  out  1  high with word DEPTH-1
busy  out  1  high in any state but IDLE
done  out  1  one-cycle pulse after last drain handshake
result  out  1  kernel result bit captured at w_enable
k_r_enable  out  1  kernel start
k_controlArr  out  1  host owns kernel array
k_init_i_t_a  out  ADDR_W  kernel init_i
k_init_acc_t_a  out  DATA_W  kernel init_acc
k_controlArrWEnable_a  out  1  array write enable
k_controlArrAddr_a  out  ADDR_W  array address
k_controlArrWData_a  out  DATA_W  array write data
k_controlArrRData_a  in  DATA_W  array read data, valid 1 cycle after a read address
k_w_enable  in  1  kernel finished
k_result  in  1  kernel result

Behaviour:
- Reset (async, rst_n=0): state=IDLE.
  - All outputs 0 except k_controlArr=1.
  - Counters, rd_pending and result cleared.
  - Reset mid-job abandons the job. Any kernel still running cannot write because k_controlArr=1; its next launch restarts it.
- States: IDLE, LOAD, LAUNCH, RUN, DRAIN.
- IDLE:
  - On start=1: latch init_i clamped to min(init_i, DEPTH) and init_acc; cnt=0; go to LOAD.
  - init_i ≥ DEPTH is sent as DEPTH. The kernel then exits without writing.
- LOAD: in_ready=1, k_controlArr=1.
  - Each in_valid&in_ready cycle writes in_data to address cnt (WEnable=1 that cycle only), then cnt++.
  - After the handshake at cnt=DEPTH-1, go to LAUNCH.
  - WEnable=0 on cycles without a handshake.
- LAUNCH (exactly 1 cycle): k_controlArr=0, k_r_enable=1, k_init_* driven from latches, in_ready=0. Go to RUN.
- RUN: k_controlArr=0, k_r_enable=0, k_init_* held.
  - k_w_enable is ignored on the LAUNCH cycle; it is undefined before the first launch.
  - When k_w_enable=1 in RUN: capture result<=k_result, cnt=0, go to DRAIN.
  - No timeout.
- DRAIN: k_controlArr=1, WEnable=0. Reads have 1-cycle latency.
  - A read of address cnt is issued when rd_pending=0, cnt<DEPTH, and (out_valid=0 or out_ready=1). On issue: cnt++ and rd_pending=1.
  - Next cycle: out_data<=RData, out_valid<=1, out_last<=(address==DEPTH-1), rd_pending=0.
  - Address is held unchanged when no read is issued.
  - out_data and out_last stay stable while out_valid=1 and out_ready=0.
  - Throughput is at most 1 word per 2 cycles; this is required behaviour.
  - On the handshake with out_last=1: out_valid=0, done=1 for one cycle, go to IDLE.
- start outside IDLE is ignored. init_i/init_acc changes outside IDLE have no effect.
- result holds until the next captured w_enable or reset.
- Arithmetic belongs to the kernel: arr[k] = init_acc + sum(arr[init_i..k]) for k ≥ init_i, with wrap-around 64-bit signed addition; words below init_i are unchanged.

Test Plan:
- Load d[k]=k+1, init_i=0, init_acc=0, out_ready=1 -> out word k = (k+1)(k+2)/2, word 999 = 500500 with out_last=1, done pulse, busy falls.
- Load d[k]=k, init_i=998, init_acc=5 -> words 0..997 = k, word 998 = 1003, word 999 = 2002.
- init_i=1023, load d[k]=7 -> kernel launched with init_i=1000, all 1000 out words = 7.
- Random in_valid gaps and random out_ready stalls -> every word delivered once, in order, with data stable during stalls; load with in_valid low 50% still produces a correct prefix sum.
- start pulsed during RUN and DRAIN -> ignored; a second job started after done runs with its own init values.
- rst_n low mid-LOAD (cnt=500) and mid-RUN -> outputs 0 with k_controlArr=1 asynchronously; a fresh job after reset gives correct results.

Source files
------------

// File: rtl/accumulate_host.sv
`default_nettype none
// ============================================================================
// Module   : accumulate_host
// Purpose  : Host-side sequencer wrapped around the `main` accumulate kernel.
//            Loads the kernel array from a valid/ready input stream, launches
//            the kernel, waits for it to finish, then streams the in-place
//            prefix-summed array back out on a valid/ready output stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   start                  job request pulse (honoured only when idle)
//   init_i, init_acc       job parameters, latched on an accepted start
//   in_valid/in_ready/
//   in_data                load stream (DEPTH words per job)
//   out_valid/out_ready/
//   out_data/out_last      drain stream (DEPTH words, last flagged)
//   busy, done, result     job status; result is the kernel result bit
//   k_*                    kernel control and array-port interface
// ============================================================================
module accumulate_host #(
    parameter int DEPTH  = 1000,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] init_i,
    input  logic [DATA_W-1:0] init_acc,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic              result,
    output logic              k_r_enable,
    output logic              k_controlArr,
    output logic [ADDR_W-1:0] k_init_i_t_a,
    output logic [DATA_W-1:0] k_init_acc_t_a,
    output logic              k_controlArrWEnable_a,
    output logic [ADDR_W-1:0] k_controlArrAddr_a,
    output logic [DATA_W-1:0] k_controlArrWData_a,
    input  logic [DATA_W-1:0] k_controlArrRData_a,
    input  logic              k_w_enable,
    input  logic              k_result
);

    // The counter is one bit wider than the address so it can hold DEPTH
    // itself (end-of-drain condition). DEPTH must be representable in ADDR_W
    // because the clamped init_i value DEPTH is sent to the kernel.
    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0]  c_depth_cnt  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  c_last_cnt   = CNT_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_depth_addr = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_LAUNCH = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   init_i_q, init_i_d;
    logic [DATA_W-1:0]   init_acc_q, init_acc_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic                rd_pending_q, rd_pending_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                done_q, done_d;
    logic                result_q, result_d;

    logic                w_rd_issue;
    logic                w_out_hs;
    logic                w_kernel_owns;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            init_i_q     <= '0;
            init_acc_q   <= '0;
            raddr_q      <= '0;
            rd_pending_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
            result_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_i_q     <= init_i_d;
            init_acc_q   <= init_acc_d;
            raddr_q      <= raddr_d;
            rd_pending_q <= rd_pending_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        init_i_d     = init_i_q;
        init_acc_d   = init_acc_q;
        raddr_d      = raddr_q;
        rd_pending_d = rd_pending_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        done_d       = 1'b0;
        result_d     = result_q;
        w_rd_issue   = 1'b0;
        w_out_hs     = out_valid_q && out_ready;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // A start index past the array makes the kernel exit
                    // without touching any word.
                    init_i_d   = ({1'b0, init_i} >= c_depth_cnt) ? c_depth_addr : init_i;
                    init_acc_d = init_acc;
                    cnt_d      = '0;
                    state_d    = S_LOAD;
                end
            end

            S_LOAD: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == c_last_cnt) begin
                        state_d = S_LAUNCH;
                    end
                end
            end

            S_LAUNCH: begin
                state_d = S_RUN;
            end

            S_RUN: begin
                if (k_w_enable) begin
                    result_d = k_result;
                    cnt_d    = '0;
                    state_d  = S_DRAIN;
                end
            end

            S_DRAIN: begin
                // Read data returns one cycle after the address; a pending
                // read always lands in an empty output register because a
                // read is only issued when the output is free or draining.
                if (rd_pending_q) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = k_controlArrRData_a;
                    out_last_d   = (raddr_q == c_last_addr);
                    rd_pending_d = 1'b0;
                end else if (w_out_hs) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        out_last_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end
                end

                if (!rd_pending_q && (cnt_q < c_depth_cnt) && (!out_valid_q || out_ready)) begin
                    w_rd_issue   = 1'b1;
                    raddr_d      = cnt_q[ADDR_W-1:0];
                    cnt_d        = cnt_q + CNT_W'(1);
                    rd_pending_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // The kernel only owns the array while it is being launched or run.
    assign w_kernel_owns = (state_q == S_LAUNCH) || (state_q == S_RUN);

    assign busy       = (state_q != S_IDLE);
    assign in_ready   = (state_q == S_LOAD);
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    assign done       = done_q;
    assign result     = result_q;

    assign k_r_enable     = (state_q == S_LAUNCH);
    assign k_controlArr   = !w_kernel_owns;
    assign k_init_i_t_a   = w_kernel_owns ? init_i_q   : '0;
    assign k_init_acc_t_a = w_kernel_owns ? init_acc_q : '0;

    assign k_controlArrWEnable_a = (state_q == S_LOAD) && in_valid;
    assign k_controlArrWData_a   = (state_q == S_LOAD) ? in_data : '0;

    // While draining, the address stays on the last issued read between issues.
    always_comb begin
        k_controlArrAddr_a = '0;
        if (state_q == S_LOAD) begin
            k_controlArrAddr_a = cnt_q[ADDR_W-1:0];
        end else if (state_q == S_DRAIN) begin
            k_controlArrAddr_a = w_rd_issue ? cnt_q[ADDR_W-1:0] : raddr_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accumulate_host.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_accumulate_host
// Purpose  : Self-checking bench for accumulate_host. Contains a behavioural
//            stand-in for the `main` kernel (array memory plus in-place
//            running sum) and a reference model of the expected drain stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accumulate_host;

    localparam int DEPTH  = 1000;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] init_i = '0;
    logic [DATA_W-1:0] init_acc = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;
    logic              result;
    logic              k_r_enable;
    logic              k_controlArr;
    logic [ADDR_W-1:0] k_init_i;
    logic [DATA_W-1:0] k_init_acc;
    logic              k_we;
    logic [ADDR_W-1:0] k_addr;
    logic [DATA_W-1:0] k_wdata;
    logic [DATA_W-1:0] k_rdata = '0;
    logic              k_wen = 1'b0;
    logic              k_res = 1'b0;

    always #5 clk = ~clk;

    accumulate_host #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .start                 (start),
        .init_i                (init_i),
        .init_acc              (init_acc),
        .in_valid              (in_valid),
        .in_ready              (in_ready),
        .in_data               (in_data),
        .out_valid             (out_valid),
        .out_ready             (out_ready),
        .out_data              (out_data),
        .out_last              (out_last),
        .busy                  (busy),
        .done                  (done),
        .result                (result),
        .k_r_enable            (k_r_enable),
        .k_controlArr          (k_controlArr),
        .k_init_i_t_a          (k_init_i),
        .k_init_acc_t_a        (k_init_acc),
        .k_controlArrWEnable_a (k_we),
        .k_controlArrAddr_a    (k_addr),
        .k_controlArrWData_a   (k_wdata),
        .k_controlArrRData_a   (k_rdata),
        .k_w_enable            (k_wen),
        .k_result              (k_res)
    );

    // ------------------------------------------------------------------
    // Kernel stand-in: array with 1-cycle read latency, host writes only
    // while the host owns it, and a run that sums in place after a random
    // latency -- but only if the kernel still owns the array at that time.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              exp_res = 1'b0;
    int                klat_lo = 3;
    int                klat_hi = 40;

    initial begin : kernel_model
        int                left;
        bit                run;
        bit                r;
        logic [ADDR_W-1:0] kii;
        logic [DATA_W-1:0] kacc;
        logic [DATA_W-1:0] a;
        run  = 1'b0;
        left = 0;
        kii  = '0;
        kacc = '0;
        for (int k = 0; k < DEPTH; k++) mem[k] = '0;
        forever begin
            @(posedge clk);
            k_rdata <= (int'(k_addr) < DEPTH) ? mem[k_addr] : '0;
            k_wen   <= 1'b0;
            if (k_controlArr && k_we && int'(k_addr) < DEPTH) mem[k_addr] = k_wdata;
            if (k_r_enable) begin
                run  = 1'b1;
                left = int'($urandom_range(klat_hi, klat_lo));
                kii  = k_init_i;
                kacc = k_init_acc;
            end else if (run) begin
                if (left == 0) begin
                    run = 1'b0;
                    r   = 1'($urandom_range(1, 0));
                    k_wen   <= 1'b1;
                    k_res   <= r;
                    exp_res <= r;
                    if (!k_controlArr) begin
                        a = kacc;
                        for (int k = int'(kii); k < DEPTH; k++) begin
                            a      = a + mem[k];
                            mem[k] = a;
                        end
                    end
                end else begin
                    left--;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: load data and expected drain stream.
    logic [DATA_W-1:0] d_arr   [0:DEPTH-1];
    logic [DATA_W-1:0] exp_arr [0:DEPTH-1];

    function automatic int eff_start(input logic [ADDR_W-1:0] ii);
        return (int'(ii) > DEPTH) ? DEPTH : int'(ii);
    endfunction

    task automatic build_job(input int pat, input logic [ADDR_W-1:0] ii, input logic [DATA_W-1:0] acc);
        logic [DATA_W-1:0] a;
        for (int k = 0; k < DEPTH; k++) begin
            case (pat)
                0:       d_arr[k] = 64'(k + 1);
                1:       d_arr[k] = 64'(k);
                2:       d_arr[k] = 64'd7;
                default: d_arr[k] = {$urandom, $urandom};
            endcase
        end
        a = acc;
        for (int k = 0; k < DEPTH; k++) begin
            if (k < eff_start(ii)) begin
                exp_arr[k] = d_arr[k];
            end else begin
                a          = a + d_arr[k];
                exp_arr[k] = a;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"},     k_controlArr, 1'b1);
        chk({tag, "_busy"},     busy, 1'b0);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_ovalid"},   out_valid, 1'b0);
        chk({tag, "_odata"},    out_data, 64'd0);
        chk({tag, "_olast"},    out_last, 1'b0);
        chk({tag, "_done"},     done, 1'b0);
        chk({tag, "_result"},   result, 1'b0);
        chk({tag, "_renable"},  k_r_enable, 1'b0);
        chk({tag, "_we"},       k_we, 1'b0);
        chk({tag, "_addr"},     k_addr, 10'd0);
        chk({tag, "_kinit"},    k_init_i, 10'd0);
    endtask

    task automatic async_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] ii, input logic [DATA_W-1:0] acc);
        @(negedge clk);
        start    = 1'b1;
        init_i   = ii;
        init_acc = acc;
        @(negedge clk);
        start    = 1'b0;
        init_i   = 10'($urandom);
        init_acc = {$urandom, $urandom};
        chk("busy_after_start", busy, 1'b1);
    endtask

    task automatic do_load(input int stop_at, input int gap_pct);
        int idx = 0;
        int cyc = 0;
        while (idx < stop_at && cyc < 10000) begin
            in_valid = (int'($urandom_range(99, 0)) >= gap_pct);
            in_data  = d_arr[idx];
            if (in_valid && in_ready) idx++;
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        if (idx < stop_at) chk("load_timeout", 64'(idx), 64'(stop_at));
        if (stop_at == DEPTH) chk("in_ready_after_load", in_ready, 1'b0);
    endtask

    task automatic do_drain(input logic [ADDR_W-1:0] ii, input logic [DATA_W-1:0] acc,
                            input int stall_pct, input int spam);
        int                oidx = 0;
        int                cyc = 0;
        int                launches = 0;
        bit                stalled = 1'b0;
        logic [DATA_W-1:0] sd = '0;
        logic              sl = 1'b0;
        while (oidx < DEPTH && cyc < 20000) begin
            out_ready = (int'($urandom_range(99, 0)) >= stall_pct);
            if (spam != 0) begin
                start    = 1'($urandom_range(1, 0));
                init_i   = 10'($urandom);
                init_acc = {$urandom, $urandom};
            end
            if (k_r_enable) begin
                launches++;
                chk("launch_init_i", k_init_i, 64'(eff_start(ii)));
                chk("launch_init_acc", k_init_acc, acc);
                chk("launch_ctrl", k_controlArr, 1'b0);
            end
            if (stalled) begin
                chk("stall_valid", out_valid, 1'b1);
                chk("stall_data", out_data, sd);
                chk("stall_last", out_last, sl);
            end
            stalled = out_valid && !out_ready;
            sd      = out_data;
            sl      = out_last;
            if (out_valid && out_ready) begin
                chk($sformatf("data[%0d]", oidx), out_data, exp_arr[oidx]);
                chk($sformatf("last[%0d]", oidx), out_last, (oidx == DEPTH - 1));
                oidx++;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        if (oidx < DEPTH) chk("drain_timeout", 64'(oidx), 64'(DEPTH));
        chk("launch_count", 64'(launches), 64'd1);
        chk("done_pulse", done, 1'b1);
        chk("busy_idle", busy, 1'b0);
        chk("ovalid_idle", out_valid, 1'b0);
        chk("result", result, exp_res);
        @(negedge clk);
        chk("done_one_cycle", done, 1'b0);
    endtask

    task automatic full_job(input int pat, input logic [ADDR_W-1:0] ii, input logic [DATA_W-1:0] acc,
                            input int gap_pct, input int stall_pct, input int spam);
        build_job(pat, ii, acc);
        do_start(ii, acc);
        do_load(DEPTH, gap_pct);
        do_drain(ii, acc, stall_pct, spam);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : main_seq
        logic [ADDR_W-1:0] ii;
        logic [DATA_W-1:0] acc;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // Triangular numbers, then start near the end, then clamped start.
        full_job(0, 10'd0, 64'd0, 0, 0, 0);
        full_job(1, 10'd998, 64'd5, 0, 0, 0);
        full_job(2, 10'd1023, 64'd12345, 0, 0, 0);

        // Random data with wrap-around, flow-control gaps and ignored starts.
        ii  = 10'($urandom_range(DEPTH - 1, 0));
        acc = {$urandom, $urandom};
        full_job(3, ii, acc, 50, 50, 1);
        ii  = 10'($urandom_range(DEPTH - 1, 0));
        acc = {$urandom, $urandom};
        full_job(0, ii, acc, 50, 30, 1);

        // Reset in the middle of the load, then a fresh job.
        build_job(3, 10'd100, 64'd9);
        do_start(10'd100, 64'd9);
        do_load(500, 20);
        async_reset("rst_load");
        full_job(3, 10'd17, {$urandom, $urandom}, 10, 10, 0);

        // Reset while the kernel is running, then a fresh job.
        klat_lo = 30;
        klat_hi = 40;
        build_job(1, 10'd0, 64'd0);
        do_start(10'd0, 64'd0);
        do_load(DEPTH, 0);
        chk("launch_pulse", k_r_enable, 1'b1);
        repeat (3) @(negedge clk);
        chk("run_ctrl", k_controlArr, 1'b0);
        chk("run_busy", busy, 1'b1);
        async_reset("rst_run");
        klat_lo = 3;
        klat_hi = 40;
        full_job(1, 10'd500, 64'd1, 20, 20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
